// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a 50% duty square wave
// with a run-time writable half-period, plus a one-cycle tick on every rising output edge.
module clk_div_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 25,
  parameter int unsigned DEF_HALF = 25000000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NCH-1:0] i_en,
  input  logic           i_wr_en,
  input  logic [3:0]     i_wr_ch,
  input  logic [CW-1:0]  i_wr_val,
  output logic [NCH-1:0] o_clk_out,
  output logic [NCH-1:0] o_tick,
  output logic           o_busy
);

  localparam logic [CW-1:0] DefHalf = CW'(DEF_HALF);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  logic [CW-1:0]  r_half [NCH];
  logic [CW-1:0]  r_cnt  [NCH];
  logic [NCH-1:0] r_clk_out;
  logic [NCH-1:0] r_tick;

  logic [CW-1:0]  w_half_d [NCH];
  logic [CW-1:0]  w_cnt_d  [NCH];
  logic [NCH-1:0] w_clk_out_d;
  logic [NCH-1:0] w_tick_d;
  logic           w_wr_ok;
  logic [NCH-1:0] w_wr_hit;

  // Zero half-periods and out-of-range channels are dropped outright.
  assign w_wr_ok = i_wr_en && (32'(i_wr_ch) < NCH) && (i_wr_val != '0);

  always_comb begin
    w_wr_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      w_wr_hit[c] = w_wr_ok && (i_wr_ch == c[3:0]);
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_half_d[c]    = r_half[c];
      w_cnt_d[c]     = r_cnt[c];
      w_clk_out_d[c] = r_clk_out[c];
      w_tick_d[c]    = 1'b0;
      if (w_wr_hit[c]) begin
        // A write pre-empts any wrap on the same edge; output level is kept while running.
        w_half_d[c] = i_wr_val;
        w_cnt_d[c]  = CntOne;
        if (!i_en[c]) begin
          w_clk_out_d[c] = 1'b0;
        end
      end else if (!i_en[c]) begin
        w_cnt_d[c]     = CntOne;
        w_clk_out_d[c] = 1'b0;
      end else if (r_cnt[c] == r_half[c]) begin
        w_cnt_d[c]     = CntOne;
        w_clk_out_d[c] = ~r_clk_out[c];
        w_tick_d[c]    = ~r_clk_out[c];
      end else begin
        w_cnt_d[c] = r_cnt[c] + CntOne;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_half[c] <= DefHalf;
        r_cnt[c]  <= CntOne;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_half[c] <= w_half_d[c];
        r_cnt[c]  <= w_cnt_d[c];
      end
      r_clk_out <= w_clk_out_d;
      r_tick    <= w_tick_d;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_busy    = |i_en;

endmodule
